// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the IF->ID fetch queue.
package fetch_queue_pkg;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;

    // One fetched instruction travelling from IF to ID.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
        logic            valid;
    } IF_ID_PACKET;

endpackage

// File: rtl/fq_storage.sv
// Packet array for the fetch queue: one write port, one asynchronous read
// port, cleared to zero on reset.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  IF_ID_PACKET   wdata,
    input  logic [AW-1:0] raddr,
    output IF_ID_PACKET   rdata
);

    IF_ID_PACKET r_mem [DEPTH];

    // Clear every entry on reset; otherwise write one entry when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID. Buffers fetched packets, shows
// the oldest to ID, stalls IF when full and supports a one-cycle flush.
// Full and empty come only from the registered count, so there is no
// combinational path from ID readiness back to IF.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  IF_ID_PACKET      if_packet_in,
    input  logic             flush,
    input  logic             id_ready,
    output logic             if_stall,
    output IF_ID_PACKET      id_packet_out,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_enq;
    logic        w_deq;
    IF_ID_PACKET w_rdata;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A full queue refuses new packets even when ID drains one this cycle.
    assign w_enq = if_packet_in.valid & ~w_full & ~flush;
    assign w_deq = id_ready & ~w_empty & ~flush;

    // Pointer and occupancy update; reset beats flush, flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (w_enq),
        .waddr (r_tail),
        .wdata (if_packet_in),
        .raddr (r_head),
        .rdata (w_rdata)
    );

    // Head packet to ID; valid is masked during flush so no wrong-path
    // packet can be consumed in the redirect cycle.
    always_comb begin
        id_packet_out       = w_rdata;
        id_packet_out.valid = ~w_empty & ~flush;
    end

    assign if_stall = w_full;
    assign count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a scoreboard.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = FQ_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    IF_ID_PACKET      if_packet_in;
    logic             flush;
    logic             id_ready;
    logic             if_stall;
    IF_ID_PACKET      id_packet_out;
    logic [CNT_W-1:0] count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_packet_in  (if_packet_in),
        .flush         (flush),
        .id_ready      (id_ready),
        .if_stall      (if_stall),
        .id_packet_out (id_packet_out),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // reference state: occupancy and the in-order list of accepted packets
    int          mdl_cnt    = 0;
    bit          just_reset = 1'b0;
    IF_ID_PACKET exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: applies the queue rules at each active edge
    always @(posedge clk) begin
        just_reset = rst;
        if (rst || flush) begin
            mdl_cnt = 0;
            exp_q.delete();
        end else begin
            bit do_enq;
            bit do_deq;
            do_enq = if_packet_in.valid && (mdl_cnt < DEPTH);
            do_deq = id_ready && (mdl_cnt > 0);
            if (do_enq) exp_q.push_back(if_packet_in);
            mdl_cnt = mdl_cnt + int'(do_enq) - int'(do_deq);
        end
    end

    // monitor: compares what the DUT presents against the model/scoreboard
    always @(negedge clk) begin
        chk("count", 128'(count), 128'(mdl_cnt));
        chk("if_stall", 128'(if_stall), 128'(mdl_cnt == DEPTH));
        chk("out_valid", 128'(id_packet_out.valid), 128'((mdl_cnt > 0) && !flush));
        chk("count_bound", 128'(int'(count) <= DEPTH), 128'(1));
        if (just_reset) chk("reset_zero", 128'(id_packet_out), 128'(0));
        if (id_packet_out.valid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", 128'(id_packet_out), 128'(0));
            end else begin
                chk("head_pkt", 128'(id_packet_out), 128'(exp_q[0]));
                if (id_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl, input logic rs);
        if_packet_in.valid = v;
        if_packet_in.PC    = pc;
        if_packet_in.NPC   = pc + 32'd4;
        if_packet_in.inst  = inst;
        id_ready           = rdy;
        flush              = fl;
        rst                = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_packet_in = '0;
        id_ready     = 1'b0;
        flush        = 1'b0;
        rst          = 1'b1;

        // 1: reset then idle
        drive(0, 32'h0, 32'h0, 0, 0, 1);
        drive(0, 32'h0, 32'h0, 0, 0, 1);
        repeat (3) drive(0, 32'h0, 32'h0, 0, 0, 0);

        // 2: single pass-through
        drive(1, 32'h8000_0000, 32'h0000_0013, 1, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);

        // 3: fill and stall; 0x10 is offered while full
        for (int i = 0; i < 5; i++) drive(1, 32'(i * 4), $urandom, 0, 0, 0);
        chk("fill_count", 128'(count), 128'(DEPTH));
        chk("fill_stall", 128'(if_stall), 128'(1));
        chk("fill_head_pc", 128'(id_packet_out.PC), 128'(32'h0));

        // 4: drain while IF keeps offering 0x10, then IF goes idle
        drive(1, 32'h10, 32'h1111_0010, 1, 0, 0);
        chk("drain_first_count", 128'(count), 128'(3));
        drive(1, 32'h10, 32'h1111_0010, 1, 0, 0);
        repeat (6) drive(0, 32'h0, 32'h0, 1, 0, 0);

        // 5: flush mid-stream with count=3
        for (int i = 0; i < 3; i++) drive(1, 32'h100 + 32'(i * 4), $urandom, 0, 0, 0);
        drive(1, 32'h1f0, 32'h0, 1, 1, 0);
        drive(1, 32'h200, 32'h2222_0200, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        chk("flush_new_head_pc", 128'(id_packet_out.PC), 128'(32'h200));
        drive(0, 32'h0, 32'h0, 1, 0, 0);

        // 6: reset mid-operation with count=2, flush and an enqueue
        drive(1, 32'h300, $urandom, 0, 0, 0);
        drive(1, 32'h304, $urandom, 0, 0, 0);
        drive(1, 32'h308, $urandom, 1, 1, 1);
        drive(0, 32'h0, 32'h0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic v, r, f, s;
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 5);
            f = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 299) == 0);
            drive(v, {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom, r, f, s);
        end
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the IF stage and the ID stage.
- Buffers IF_ID_PACKETs produced by IF, so short ID back-pressure does not drop fetched instructions.
- Presents the oldest packet to ID and raises a stall back to IF when it is full.
- Supports a single-cycle flush for redirects (branch, jump, exception).

Parameters:
- DEPTH, 4: number of packet entries. Must be a power of two, 2 to 16.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count. Derived; never overridden.

Ports:
- clk  input  1  single system clock; all state updates on the posedge.
- rst  input  1  synchronous, active-high reset.
- if_packet_in  input  IF_ID_PACKET  packet from IF; enqueue is requested when if_packet_in.valid=1.
- flush  input  1  discard all buffered packets (redirect).
- id_ready  input  1  ID accepts the head packet this cycle.
- if_stall  output  1  queue full; drives the IF stage stall input.
- id_packet_out  output  IF_ID_PACKET  head packet to ID; .valid marks a valid packet.
- count  output  CNT_W  current occupancy, for debug and perf counters.

Behaviour:
- State: storage array of DEPTH packets; head pointer and tail pointer of $clog2(DEPTH) bits; count register.
- Pointers wrap modulo DEPTH by natural overflow.
- full = (count == DEPTH); empty = (count == 0). Both are decoded from the registered count only.
- enq = if_packet_in.valid & ~full & ~flush.
- deq = id_ready & ~empty & ~flush.
- On enq: write the packet at tail and increment tail.
- On deq: increment head.
- count update: count <= count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- When full, enq is refused even if deq fires that cycle. There is no pass-through when full, so the full path stays purely registered.
  - IF must hold its packet while if_stall=1.
  - Any packet presented while full is not captured.
- Latency: a packet enqueued at edge N is visible on id_packet_out in the cycle after edge N. There is no combinational bypass when empty, so minimum latency IF→ID is 1 cycle.
- id_packet_out is the storage[head] fields, with .valid = ~empty & ~flush.
  - The flush mask is combinational, so ID never consumes a wrong-path packet in the flush cycle.
- if_stall = full, combinational from the registered count.
- flush:
  - At the next edge, head, tail and count go to 0.
  - Overrides enq and deq in the same cycle.
  - Storage contents are left as-is (don't-care, since valid is masked).
  - From the cycle after the flush, the queue accepts new packets normally.
- Reset (rst=1 at a posedge), with priority over flush and all traffic:
  - head, tail and count go to 0.
  - All storage entries are cleared to zero.
- Outputs after reset: id_packet_out all-zero with valid=0; if_stall=0; count=0.
- Reset asserted mid-operation discards all contents identically.
- Storage never holds packets with valid=0. Invalid IF cycles are simply not enqueued.
- count never exceeds DEPTH and never underflows. Verification asserts both.

Decomposition:
- IF_ID_PACKET (inst[`XLEN-1:0], PC, NPC, valid) stays in sys_defs.svh.
- Add `FQ_DEPTH (default 4) to sys_defs.svh; the top level passes it to DEPTH.
- One sub-module, fq_storage, holds the packet array:
  - one write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata);
  - synchronous clear on rst.
- Pointer, count, flush and handshake logic remain in fetch_queue.

Test Plan:
1. Reset then idle.
   - Stimulus: rst=1 for 2 cycles, then if_packet_in.valid=0.
   - Required: id_packet_out.valid=0, if_stall=0, count=0 on every cycle.
2. Single pass-through.
   - Stimulus: packet PC=0x80000000, inst=0x00000013, valid=1 for one cycle; id_ready=1.
   - Required: the next cycle shows valid=1, PC=0x80000000, NPC=0x80000004. The cycle after that, count=0 and valid=0.
3. Fill and stall.
   - Stimulus: id_ready=0; 5 consecutive valid packets PC=0x0,0x4,0x8,0xC,0x10.
   - Required: after 4 edges count=4 and if_stall=1. PC 0x10 is not captured. The head stays at PC=0x0.
4. Drain with simultaneous traffic and wrap-around.
   - Stimulus: from the full state, id_ready=1. IF holds PC=0x10 with valid=1.
   - Required: the first cycle dequeues 0x0 with no enqueue (full), and count=3.
   - Required: the next cycles dequeue and enqueue together, with count steady at 3 until IF stops.
   - Required: in-order delivery 0x0,0x4,0x8,0xC,0x10; the tail wraps from 3 to 0.
5. Flush mid-stream.
   - Stimulus: count=3; flush=1 in the same cycle as if_packet_in.valid=1 and id_ready=1.
   - Required: id_packet_out.valid=0 in that cycle. Next cycle count=0 and if_stall=0; the flushed-cycle packet is not enqueued.
   - Required: a new packet PC=0x200 appears at the head one cycle after being enqueued.
6. Reset mid-operation.
   - Stimulus: count=2, rst=1 together with flush=1 and an enqueue.
   - Required: next cycle count=0, id_packet_out all-zero with valid=0, if_stall=0.
